// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide unit that holds the pipeline while it iterates.
// One shared shift/add-subtract datapath: WIDTH cycles per operation, one cycle for divide-by-zero.
module muldiv_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             isDiv,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] resultLo,
   output logic [WIDTH-1:0] resultHi,
   output logic             divByZero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic             is_div_reg;
   logic [WIDTH-1:0] oper_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic [WIDTH-1:0] result_lo_reg;
   logic [WIDTH-1:0] result_hi_reg;
   logic             div_by_zero_reg;

   logic [WIDTH-1:0] hi_next;
   logic [WIDTH-1:0] lo_next;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   div_diff;
   logic             last_iter;

   // oper_reg holds the multiplicand for multiply and the divisor for divide
   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, oper_reg} : {(WIDTH+1){1'b0}});
      rem_shift = {hi_reg, lo_reg[WIDTH-1]};
      div_diff  = rem_shift - {1'b0, oper_reg};
      hi_next   = mul_sum[WIDTH:1];
      lo_next   = {mul_sum[0], lo_reg[WIDTH-1:1]};
      if (is_div_reg) begin
         if (div_diff[WIDTH]) begin
            hi_next = rem_shift[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], 1'b0};
         end else begin
            hi_next = div_diff[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], 1'b1};
         end
      end
   end

   assign last_iter = (cnt_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         is_div_reg      <= 1'b0;
         oper_reg        <= '0;
         hi_reg          <= '0;
         lo_reg          <= '0;
         result_lo_reg   <= '0;
         result_hi_reg   <= '0;
         div_by_zero_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  is_div_reg      <= isDiv;
                  cnt_reg         <= '0;
                  div_by_zero_reg <= 1'b0;
                  if (isDiv && (opB == '0)) begin
                     result_lo_reg   <= '1;
                     result_hi_reg   <= opA;
                     div_by_zero_reg <= 1'b1;
                     state_reg       <= DONE;
                  end else begin
                     oper_reg  <= isDiv ? opB : opA;
                     hi_reg    <= '0;
                     lo_reg    <= isDiv ? opA : opB;
                     state_reg <= RUN;
                  end
               end
            end
            RUN: begin
               hi_reg  <= hi_next;
               lo_reg  <= lo_next;
               cnt_reg <= cnt_reg + CW'(1);
               if (last_iter) begin
                  result_lo_reg <= lo_next;
                  result_hi_reg <= hi_next;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_reg == RUN) || (state_reg == DONE);
   assign done      = (state_reg == DONE);
   assign stall     = ((state_reg == IDLE) && start) || (state_reg == RUN);
   assign resultLo  = result_lo_reg;
   assign resultHi  = result_hi_reg;
   assign divByZero = div_by_zero_reg;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle unsigned multiply/divide unit with its own sequencing FSM. It sits beside the ALU in the execute stage. It is launched when the control unit decodes a type-A instruction with the `multiDiv` flag set. While it iterates, it holds the pipeline with `stall`. One shared shift/add-subtract datapath serves both operations: WIDTH cycles per operation, plus a one-cycle fast path for divide-by-zero.

## Interface
- `WIDTH`, default 16: operand width. Results are two WIDTH-bit halves.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `isDiv`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `opA`  in  WIDTH  multiplicand or dividend; sampled with `start`.
- `opB`  in  WIDTH  multiplier or divisor; sampled with `start`.
- `busy`  out  1  high in RUN and DONE.
- `stall`  out  1  combinational: (IDLE & `start`) | RUN.
- `done`  out  1  one-cycle pulse; the result is valid from this cycle on.
- `resultLo`  out  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient.
- `resultHi`  out  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder.
- `divByZero`  out  1  set with `done` when a divide had `opB`==0; held with the result.

## Operation
- States:
  - IDLE: `start`=1 latches `isDiv`, `opA`, `opB`, clears the iteration counter and goes to RUN. Exception: a divide with `opB`==0 goes directly to DONE.
  - RUN: performs one iteration per cycle. Goes to DONE after WIDTH iterations, i.e. when the counter reaches WIDTH-1.
  - DONE: asserts `done` and always returns to IDLE on the next cycle.
- Multiply (shift-add):
  - Accumulator is {hi, lo} with lo = multiplier.
  - Each cycle: if lo[0], hi += multiplicand using a WIDTH+1-bit sum, the carry included.
  - Then shift {carry, hi, lo} right by 1.
- Divide (restoring):
  - Each cycle, shift {rem, quo} left by 1, bringing the dividend MSB into rem.
  - If rem ≥ divisor: rem -= divisor and quo[0] = 1; otherwise quo[0] = 0.
  - The compare uses a WIDTH+1-bit subtract.
- Divide by zero: `resultLo` = all ones, `resultHi` = `opA`, `divByZero` = 1.
- `resultLo`, `resultHi` and `divByZero` update only when entering DONE. They hold stable through IDLE until the next result is written. `divByZero` clears on the next accepted `start`.
- `start` in RUN or DONE is ignored. It is neither queued nor able to corrupt operands. The pipeline re-presents the request after `stall` drops.
- Operand inputs may change freely after the acceptance cycle.

## Timing
- Reset (async assert, sync-safe release):
  - state = IDLE, counter = 0.
  - `busy`, `stall`, `done`, `divByZero` = 0; `resultLo`, `resultHi` = 0.
- Reset asserted mid-operation aborts immediately. No `done` pulse is produced and the partial result is discarded.
- `start` accepted at edge E0 (cycle 0):
  - RUN during cycles 1..WIDTH.
  - `done`=1 in cycle WIDTH+1.
  - Latency from accepting edge to `done` = WIDTH+1 cycles (17 for WIDTH=16).
- Divide by zero: `done`=1 in cycle 1.
- `stall` is high in cycle 0 (combinational on `start`) and through the last RUN cycle. It is low in the DONE cycle, so the pipeline advances and captures the result there.
- Earliest next acceptance is in the IDLE cycle after DONE, so back-to-back operations are spaced WIDTH+2 cycles.
- Counter is ceil(log2(WIDTH)) bits. It never wraps inside an operation and is reset on each accept.

## Test plan
- Reset and idle:
  - Assert `rst_n`=0 mid-RUN of 7*9 → all outputs 0 asynchronously.
  - Release reset and hold `start` low for 20 cycles → no `done` pulse.
- Multiply (WIDTH=16):
  - 7*9 → `done` at cycle 17; `resultLo`=63, `resultHi`=0; `stall` high in cycles 0-16, low in 17.
  - 0xFFFF*0xFFFF → `resultHi`=0xFFFE, `resultLo`=0x0001 (carry path).
- Divide (WIDTH=16):
  - 100/7 → quotient 14, remainder 2 at cycle 17.
  - 0xFFFF/1 → quotient 0xFFFF, remainder 0.
  - 5/9 → quotient 0, remainder 5.
- Divide by zero: 1234/0 → `done` at cycle 1; `divByZero`=1, `resultLo`=0xFFFF, `resultHi`=1234. A following 6*6 clears `divByZero` on accept and yields 36.
- Busy protection:
  - Pulse `start` with 3*3 at cycle 5 of 10*10 → ignored; result 100 at cycle 17.
  - `start` held high through DONE → a new operation is accepted only in the following IDLE cycle (cycle 18).
- Result hold: after `done`, the outputs remain unchanged for 50 idle cycles while `opA`/`opB` toggle randomly.
